// File: rtl/ctr_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller: state codes, opcodes and
// datapath select encodings.
package ctr_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRWb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } ctr_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the unified memory and are therefore watched by the watchdog.
  function automatic logic is_mem_state(ctr_state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/multi_cycle_ctr_if.sv
// Control bundle between the main controller (master) and the multi-cycle datapath/memory
// (slave).
interface multi_cycle_ctr_if;

  logic [5:0] opCode;
  logic       zero;
  logic       memReady;
  logic [1:0] aluOp;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       iOrD;
  logic       irWrite;
  logic       pcWrite;
  logic       pcWriteCond;
  logic [1:0] pcSource;
  logic       illegalOp;
  logic       memError;
  logic [3:0] state;

  modport master (
    input  opCode, zero, memReady,
    output aluOp, aluSrcA, aluSrcB, regDst, memToReg, regWrite, memRead, memWrite, iOrD,
           irWrite, pcWrite, pcWriteCond, pcSource, illegalOp, memError, state
  );

  modport slave (
    output opCode, zero, memReady,
    input  aluOp, aluSrcA, aluSrcB, regDst, memToReg, regWrite, memRead, memWrite, iOrD,
           irWrite, pcWrite, pcWriteCond, pcSource, illegalOp, memError, state
  );

endinterface

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive memory stall cycles and flags expiry in the cycle the count would reach
// WAIT_LIMIT; a WAIT_LIMIT of 0 disables it.
module mem_wait_watchdog #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  output logic expire_o
);

  localparam int unsigned CntW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CntW-1:0] LastCnt = (WAIT_LIMIT == 0) ? '0 : CntW'(WAIT_LIMIT - 1);
  localparam logic Enabled = (WAIT_LIMIT != 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The limit cycle is itself a stall; memReady in that cycle deasserts wait_i and wins.
  assign expire_o = Enabled && wait_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = '0;
    if (Enabled && wait_i && !expire_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle MIPS main control FSM: decodes opCode and sequences PC, IR, memory, register
// file and ALU operand muxes against a variable-latency memory.
module multi_cycle_ctr
  import ctr_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic               clk,
  input logic               reset,
  multi_cycle_ctr_if.master bus
);

  ctr_state_e state_q, state_d;

  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       mem_wait;
  logic       expire;

  // Branch resolution happens in the datapath through pcWriteCond.
  logic unused_zero;
  assign unused_zero = bus.zero;

  assign mem_wait = is_mem_state(state_q) && !bus.memReady;

  mem_wait_watchdog #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .wait_i  (mem_wait),
    .expire_o(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_op        = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = bus.memReady;
        pc_write  = bus.memReady;
        if (bus.memReady) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = SRCB_IMM_SH2;
        case (bus.opCode)
          OP_RTYPE:      state_d = StExec;
          OP_LW, OP_SW:  state_d = StMemAdr;
          OP_BEQ:        state_d = StBranch;
          OP_J:          state_d = StJump;
          OP_ADDI:       state_d = StAddiEx;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (state_q == StAddiEx) begin
          state_d = StAddiWb;
        end else begin
          state_d = (bus.opCode == OP_LW) ? StMemRd : StMemWr;
        end
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.memReady) state_d = StMemWb;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.memReady) state_d = StFetch;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Expiry only occurs while stalled, so it never overrides a completing access.
    if (expire) state_d = StFetch;
  end

  // Reset gates everything combinationally so an in-flight write drops with reset.
  assign bus.aluOp       = reset ? 2'b00 : alu_op;
  assign bus.aluSrcA     = alu_src_a & ~reset;
  assign bus.aluSrcB     = reset ? 2'b00 : alu_src_b;
  assign bus.regDst      = reg_dst & ~reset;
  assign bus.memToReg    = mem_to_reg & ~reset;
  assign bus.regWrite    = reg_write & ~reset;
  assign bus.memRead     = mem_read & ~reset;
  assign bus.memWrite    = mem_write & ~reset;
  assign bus.iOrD        = i_or_d & ~reset;
  assign bus.irWrite     = ir_write & ~reset;
  assign bus.pcWrite     = pc_write & ~reset;
  assign bus.pcWriteCond = pc_write_cond & ~reset;
  assign bus.pcSource    = reset ? 2'b00 : pc_source;
  assign bus.illegalOp   = illegal_op & ~reset;
  assign bus.memError    = expire & ~reset;
  assign bus.state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Self-checking bench for multi_cycle_ctr: directed scenarios plus random instruction streams
// checked against a per-instruction sequence model.
module tb_multi_cycle_ctr;

  localparam int unsigned WL = 3;
  localparam logic [5:0] OPR = 6'b000000, OPLW = 6'b100011, OPSW = 6'b101011;
  localparam logic [5:0] OPBEQ = 6'b000100, OPJ = 6'b000010, OPADDI = 6'b001000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  int st_q[$];
  bit rdy_q[$];
  bit ill_q[$];
  bit err_q[$];

  multi_cycle_ctr_if bus_if ();

  multi_cycle_ctr #(
    .WAIT_LIMIT(WL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] act_ctl();
    return {bus_if.aluOp, bus_if.aluSrcA, bus_if.aluSrcB, bus_if.regDst, bus_if.memToReg,
            bus_if.regWrite, bus_if.memRead, bus_if.memWrite, bus_if.iOrD, bus_if.irWrite,
            bus_if.pcWrite, bus_if.pcWriteCond, bus_if.pcSource, bus_if.illegalOp,
            bus_if.memError};
  endfunction

  // Control word expected in a given state, straight from the per-state output table.
  function automatic logic [17:0] exp_ctl(int st, bit rdy, bit ill, bit err);
    logic [1:0] aop, srcb, pcs;
    logic srca, rd, m2r, rw, mr, mw, iod, irw, pcw, pcc;
    {aop, srcb, pcs} = '0;
    {srca, rd, m2r, rw, mr, mw, iod, irw, pcw, pcc} = '0;
    case (st)
      0: begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1: srcb = 2'b11;
      2, 10: begin srca = 1; srcb = 2'b10; end
      3: begin mr = 1; iod = 1; end
      4: begin m2r = 1; rw = 1; end
      5: begin mw = 1; iod = 1; end
      6: begin srca = 1; aop = 2'b10; end
      7: begin rd = 1; rw = 1; end
      8: begin srca = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      9: begin pcw = 1; pcs = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {aop, srca, srcb, rd, m2r, rw, mr, mw, iod, irw, pcw, pcc, pcs, ill, err};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int st, bit rdy, bit ill, bit err);
    st_q.push_back(st);
    rdy_q.push_back(rdy);
    ill_q.push_back(ill);
    err_q.push_back(err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.memReady = 1'b0;
    bus_if.opCode = OPR;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 4'd0 || act_ctl() !== 18'd0)
      $display("FAIL reset_hold: state %0d ctl %b, expected 0 and all zero", bus_if.state,
               act_ctl());
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_if.memRead !== 1'b1 || bus_if.aluSrcB !== 2'b01)
      $display("FAIL reset_release: memRead %b aluSrcB %b, expected 1 01", bus_if.memRead,
               bus_if.aluSrcB);
    else n_pass++;
    bus_if.memReady = 1'b1;
    next_cycle();
    @(posedge clk);
    #2;
    n_checks++;
    if (bus_if.state !== 4'd6) $display("FAIL reset_reach_exec: state %0d, expected 6",
                                        bus_if.state);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus_if.state !== 4'd0 || act_ctl() !== 18'd0)
      $display("FAIL reset_mid_exec: state %0d ctl %b, expected 0 and all zero", bus_if.state,
               act_ctl());
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_if.state !== 4'd0 || bus_if.memRead !== 1'b1 || bus_if.aluSrcB !== 2'b01)
      $display("FAIL reset_mid_release: state %0d memRead %b aluSrcB %b, expected 0 1 01",
               bus_if.state, bus_if.memRead, bus_if.aluSrcB);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    do_reset();
    bus_if.opCode = OPR;
    bus_if.memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.state !== 4'(exp_st[i]))
        $display("FAIL rtype_state[%0d]: got %0d, expected %0d", i, bus_if.state, exp_st[i]);
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (bus_if.aluOp !== 2'b10) $display("FAIL rtype_aluop: got %b, expected 10",
                                             bus_if.aluOp);
        else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if ({bus_if.regWrite, bus_if.regDst} !== 2'b11)
          $display("FAIL rtype_wb: regWrite/regDst %b%b, expected 11", bus_if.regWrite,
                   bus_if.regDst);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_lw_wait();
    int exp_st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    bit rdy[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    do_reset();
    bus_if.opCode = OPLW;
    for (int i = 0; i < 8; i++) begin
      bus_if.memReady = rdy[i];
      @(negedge clk);
      n_checks++;
      if (bus_if.state !== 4'(exp_st[i]))
        $display("FAIL lw_state[%0d]: got %0d, expected %0d", i, bus_if.state, exp_st[i]);
      else n_pass++;
      if (i >= 3 && i <= 5) begin
        n_checks++;
        if ({bus_if.memRead, bus_if.iOrD, bus_if.memWrite, bus_if.memError} !== 4'b1100)
          $display("FAIL lw_memrd[%0d]: memRead/iOrD/memWrite/memError %b%b%b%b, expected 1100",
                   i, bus_if.memRead, bus_if.iOrD, bus_if.memWrite, bus_if.memError);
        else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if ({bus_if.regWrite, bus_if.memToReg, bus_if.regDst} !== 3'b110)
          $display("FAIL lw_wb: regWrite/memToReg/regDst %b%b%b, expected 110",
                   bus_if.regWrite, bus_if.memToReg, bus_if.regDst);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_beq_j();
    int exp_st[7] = '{0, 1, 8, 0, 1, 9, 0};
    do_reset();
    bus_if.memReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_if.opCode = (i < 3) ? OPBEQ : OPJ;
      @(negedge clk);
      n_checks++;
      if (bus_if.state !== 4'(exp_st[i]))
        $display("FAIL beqj_state[%0d]: got %0d, expected %0d", i, bus_if.state, exp_st[i]);
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if ({bus_if.aluOp, bus_if.pcWriteCond, bus_if.pcSource, bus_if.pcWrite} !== 6'b011010)
          $display("FAIL beq_ctl: aluOp %b pcWriteCond %b pcSource %b pcWrite %b", bus_if.aluOp,
                   bus_if.pcWriteCond, bus_if.pcSource, bus_if.pcWrite);
        else n_pass++;
      end
      if (i == 5) begin
        n_checks++;
        if ({bus_if.pcWrite, bus_if.pcSource, bus_if.pcWriteCond} !== 4'b1100)
          $display("FAIL j_ctl: pcWrite %b pcSource %b pcWriteCond %b, expected 1 10 0",
                   bus_if.pcWrite, bus_if.pcSource, bus_if.pcWriteCond);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    int exp_st[3] = '{0, 1, 0};
    bit exp_ill[3] = '{0, 1, 0};
    do_reset();
    bus_if.opCode = 6'b111111;
    bus_if.memReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.state !== 4'(exp_st[i]) || bus_if.illegalOp !== exp_ill[i])
        $display("FAIL illegal[%0d]: state %0d illegalOp %b, expected %0d %b", i, bus_if.state,
                 bus_if.illegalOp, exp_st[i], exp_ill[i]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_watchdog();
    bit exp_err;
    do_reset();
    bus_if.opCode = OPR;
    bus_if.memReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_err = (i == 2) || (i == 5);
      @(negedge clk);
      n_checks++;
      if (bus_if.state !== 4'd0 || bus_if.memError !== exp_err || bus_if.irWrite !== 1'b0)
        $display("FAIL wdog_stall[%0d]: state %0d memError %b irWrite %b, expected 0 %b 0", i,
                 bus_if.state, bus_if.memError, bus_if.irWrite, exp_err);
      else n_pass++;
      next_cycle();
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus_if.memReady = (i == 2);
      @(negedge clk);
      n_checks++;
      if (bus_if.state !== ((i == 3) ? 4'd1 : 4'd0) || bus_if.memError !== 1'b0 ||
          bus_if.irWrite !== (i == 2))
        $display("FAIL wdog_ready[%0d]: state %0d memError %b irWrite %b", i, bus_if.state,
                 bus_if.memError, bus_if.irWrite);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_random();
    int sel, fw, mwt, mst;
    logic [5:0] op;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 6);
      fw  = $urandom_range(0, 2);
      mwt = $urandom_range(0, 3);
      case (sel)
        0: op = OPR;
        1: op = OPLW;
        2: op = OPSW;
        3: op = OPBEQ;
        4: op = OPJ;
        5: op = OPADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op inside {OPR, OPLW, OPSW, OPBEQ, OPJ, OPADDI}) op = 6'($urandom_range(0, 63));
        end
      endcase
      st_q.delete();
      rdy_q.delete();
      ill_q.delete();
      err_q.delete();
      repeat (fw) push(0, 0, 0, 0);
      push(0, 1, 0, 0);
      push(1, bit'($urandom_range(0, 1)), sel == 6, 0);
      case (sel)
        0: begin push(6, bit'($urandom_range(0, 1)), 0, 0); push(7, 1, 0, 0); end
        5: begin push(10, bit'($urandom_range(0, 1)), 0, 0); push(11, 0, 0, 0); end
        3: push(8, bit'($urandom_range(0, 1)), 0, 0);
        4: push(9, bit'($urandom_range(0, 1)), 0, 0);
        1, 2: begin
          mst = (sel == 1) ? 3 : 5;
          push(2, bit'($urandom_range(0, 1)), 0, 0);
          if (mwt < int'(WL)) begin
            repeat (mwt) push(mst, 0, 0, 0);
            push(mst, 1, 0, 0);
            if (sel == 1) push(4, bit'($urandom_range(0, 1)), 0, 0);
          end else begin
            repeat (WL - 1) push(mst, 0, 0, 0);
            push(mst, 0, 0, 1);
          end
        end
        default: ;
      endcase
      bus_if.opCode = op;
      for (int i = 0; i < st_q.size(); i++) begin
        bus_if.memReady = rdy_q[i];
        @(negedge clk);
        n_checks++;
        if (bus_if.state !== 4'(st_q[i]) ||
            act_ctl() !== exp_ctl(st_q[i], rdy_q[i], ill_q[i], err_q[i]))
          $display("FAIL random[%0d.%0d] op=%b: state %0d ctl %b, expected state %0d ctl %b", n,
                   i, op, bus_if.state, act_ctl(), st_q[i],
                   exp_ctl(st_q[i], rdy_q[i], ill_q[i], err_q[i]));
        else n_pass++;
        next_cycle();
      end
    end
  endtask

  initial begin
    bus_if.opCode = 6'd0;
    bus_if.zero = 1'b0;
    bus_if.memReady = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq_j();
    test_illegal();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
